// File: rtl/mul_share_pkg.sv
// mul_share_pkg
// Shared constants, types and the round-robin pick helper for mul_share_arb.
//   OPW / PRODW    : operand and product widths of the shared multiplier.
//   MAXREQ/MAXIDW  : largest supported requester count and its id width.
//   out_state_e    : occupancy state of the output register.
//   rr_pick()      : first valid requester after 'last', wrapping modulo nreq.
package mul_share_pkg;

    localparam int OPW    = 16;
    localparam int PRODW  = 32;
    localparam int MAXREQ = 16;
    localparam int MAXIDW = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    typedef struct packed {
        logic              found;
        logic [MAXIDW-1:0] idx;
    } rr_pick_t;

    // Scans last+1, last+2, ... (mod nreq) and returns the first valid index.
    // Vectors are sized for the maximum requester count so one function
    // serves every NREQ; bits at or above nreq are never looked at.
    function automatic rr_pick_t rr_pick(input logic [MAXREQ-1:0] valid,
                                         input logic [MAXIDW-1:0] last,
                                         input int                nreq);
        rr_pick_t r;
        int       cand;
        r = '0;
        for (int k = 1; k <= MAXREQ; k++) begin
            cand = (int'(last) + k) % nreq;
            if (k <= nreq && !r.found && valid[cand[MAXIDW-1:0]]) begin
                r.found = 1'b1;
                r.idx   = cand[MAXIDW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_share_arb_if.sv
// mul_share_arb_if
// Bundles the NREQ request channels and the single result channel.
//   in_valid/in_ready : per-requester valid/ready; in_ready is a one-hot grant.
//   in_a/in_b         : signed 16-bit operands, requester i at [16*i+15:16*i].
//   out_valid/out_ready, out_id, out_product : tagged 32-bit signed result.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; a source holding valid keeps its payload stable until then.
// Modports: slave = the arbiter block, master = the requesters/consumer side.
interface mul_share_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    in_valid;
    logic [NREQ*16-1:0] in_a;
    logic [NREQ*16-1:0] in_b;
    logic [NREQ-1:0]    in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [IDW-1:0]     out_id;
    logic [31:0]        out_product;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_id, out_product
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_id, out_product
    );
endinterface

// File: rtl/mul_share_rr_arb.sv
// mul_share_rr_arb
// Round-robin pointer plus combinational grant.
//   clk, rst_n : clock, asynchronous active-low reset.
//   en         : grants allowed this cycle (low while the output is stalled).
//   valid      : per-requester request valid.
//   grant      : one-hot winner, zero when nothing is granted.
//   win_id     : winner index (meaningful when found=1).
//   found      : a grant is issued this cycle.
module mul_share_rr_arb
    import mul_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  win_id,
    output logic            found
);
    logic [IDW-1:0] last_q, last_d;
    rr_pick_t       pick;

    always_comb begin
        pick   = rr_pick(MAXREQ'(valid), MAXIDW'(last_q), NREQ);
        win_id = pick.idx[IDW-1:0];
        found  = en & pick.found;
        grant  = found ? (NREQ'(1) << win_id) : '0;
        last_d = found ? win_id : last_q;
    end

    // Pointer resets to the top index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= IDW'(NREQ - 1);
        else        last_q <= last_d;
    end
endmodule

// File: rtl/mul_tc_16_16.sv
// mul_tc_16_16
// Combinational 16x16 signed two's-complement multiplier, full 32-bit product.
//   a, b    : signed operands.
//   product : a*b, no truncation.
module mul_tc_16_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] product
);
    // Sign-extend to the product width first so the multiply is 32x32->32.
    assign product = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb
// Shares one mul_tc_16_16 between NREQ requesters. A round-robin arbiter
// picks one operand pair per cycle; the product is registered and returned
// tagged with the requester id. Output backpressure stalls the whole block.
//   clk, rst_n : clock, asynchronous active-low reset.
//   bus        : mul_share_arb_if.slave (request channels + result channel).
//   dbg_state  : output register occupancy (EMPTY/FULL), mirrors out_valid.
// Build option MUL_SHARE_PIPE2_EN: adds a register stage holding the muxed
// operands and id ahead of the multiplier (latency 2, still 1 result/cycle).
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    mul_share_arb_if.slave      bus,
    output out_state_e          dbg_state
);
    out_state_e       state_q, state_d;
    logic [IDW-1:0]   out_id_q, out_id_d;
    logic [PRODW-1:0] out_product_q, out_product_d;

    logic             stall;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   win_id;
    logic             found;
    logic [OPW-1:0]   sel_a, sel_b;
    logic [OPW-1:0]   mul_a, mul_b;
    logic [PRODW-1:0] product;
    logic             load;
    logic [IDW-1:0]   load_id;

`ifdef MUL_SHARE_PIPE2_EN
    logic             s1_valid_q, s1_valid_d;
    logic [OPW-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [IDW-1:0]   s1_id_q, s1_id_d;
`endif

    // A full output nobody is taking freezes every stage and blocks grants.
    assign stall = (state_q == ST_FULL) & ~bus.out_ready;

    mul_share_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (~stall),
        .valid  (bus.in_valid),
        .grant  (grant),
        .win_id (win_id),
        .found  (found)
    );

    mul_tc_16_16 u_mul (
        .a       (mul_a),
        .b       (mul_b),
        .product (product)
    );

    always_comb begin
        sel_a = bus.in_a[win_id*OPW +: OPW];
        sel_b = bus.in_b[win_id*OPW +: OPW];
`ifdef MUL_SHARE_PIPE2_EN
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        if (!stall) begin
            s1_valid_d = found;
            if (found) begin
                s1_a_d  = sel_a;
                s1_b_d  = sel_b;
                s1_id_d = win_id;
            end
        end
        mul_a   = s1_a_q;
        mul_b   = s1_b_q;
        load    = s1_valid_q & ~stall;
        load_id = s1_id_q;
`else
        mul_a   = sel_a;
        mul_b   = sel_b;
        load    = found;   // found is already gated by ~stall
        load_id = win_id;
`endif
    end

    // Output register FSM: EMPTY <-> FULL; a stalled FULL holds everything.
    always_comb begin
        state_d       = state_q;
        out_id_d      = out_id_q;
        out_product_d = out_product_q;
        if (!stall) begin
            state_d = load ? ST_FULL : ST_EMPTY;
        end
        if (load) begin
            out_id_d      = load_id;
            out_product_d = product;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            out_id_q      <= '0;
            out_product_q <= '0;
        end else begin
            state_q       <= state_d;
            out_id_q      <= out_id_d;
            out_product_q <= out_product_d;
        end
    end

`ifdef MUL_SHARE_PIPE2_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
        end
    end
`endif

    assign bus.in_ready    = grant;
    assign bus.out_valid   = (state_q == ST_FULL);
    assign bus.out_id      = out_id_q;
    assign bus.out_product = out_product_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb
// Directed bench for mul_share_arb (single-stage build). A negedge compare
// process keeps a small model (result-pending flag, round-robin pointer and
// an expected-result queue) and checks grants and outputs every cycle; the
// directed sequence adds literal expectations computed by hand.
module tb_mul_share_arb;
    import mul_share_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = $clog2(NREQ);
    localparam int W    = IDW + 32;

    logic       clk;
    logic       rst_n;
    out_state_e dbg_state;

    mul_share_arb_if #(.NREQ(NREQ)) bus();

    mul_share_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];
    int   m_last  = NREQ - 1;
    logic m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mul_ref(input logic [15:0] a, input logic [15:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p;
    endfunction

    // Per-cycle model checks; also computes the state after the coming edge.
    always @(negedge clk) begin : compare
        int       win;
        logic     stall_m;
        logic [W-1:0] ent;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_last  = NREQ - 1;
            exp_q.delete();
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        end else begin
            stall_m = m_valid && !bus.out_ready;
            win = -1;
            if (!stall_m) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int idx;
                    idx = (m_last + k) % NREQ;
                    if (win < 0 && bus.in_valid[idx]) win = idx;
                end
            end
            check("in_ready", 32'(bus.in_ready), (win >= 0) ? (32'd1 << win) : 32'd0);
            check("out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    check("out_id", 32'(bus.out_id), 32'(exp_q[0][W-1:32]));
                    check("out_product", bus.out_product, exp_q[0][31:0]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            if (!stall_m) begin
                if (win >= 0) begin
                    ent[W-1:32] = IDW'(win);
                    ent[31:0]   = mul_ref(bus.in_a[16*win +: 16], bus.in_b[16*win +: 16]);
                    exp_q.push_back(ent);
                    m_valid = 1'b1;
                    m_last  = win;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.in_valid[i]       = 1'b1;
        bus.in_a[16*i +: 16]  = a;
        bus.in_b[16*i +: 16]  = b;
    endtask

    task automatic clr_req(input int i);
        bus.in_valid[i] = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [NREQ-1:0] g;
        rst_n         = 1'b0;
        bus.in_valid  = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_id", 32'(bus.out_id), 32'd0);
        check("reset out_product", bus.out_product, 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd0);
        check("reset dbg_state", 32'(dbg_state), 32'(ST_EMPTY));
        rst_n = 1'b1;
        step();

        // single request from requester 0
        set_req(0, 16'hBA86, 16'h794D);
        #1 check("single grant", 32'(bus.in_ready), 32'b0001);
        step();
        clr_req(0);
        check("single out_valid", 32'(bus.out_valid), 32'd1);
        check("single out_id", 32'(bus.out_id), 32'd0);
        check("single product", bus.out_product, 32'hDF14704E);
        step();
        check("single drained", 32'(bus.out_valid), 32'd0);

        // signed corners from requester 1, one per cycle
        set_req(1, 16'h8000, 16'h8000);
        step();
        check("corner1 id", 32'(bus.out_id), 32'd1);
        check("corner1 product", bus.out_product, 32'h40000000);
        set_req(1, 16'hFFFF, 16'h0001);
        step();
        check("corner2 product", bus.out_product, 32'hFFFFFFFF);
        set_req(1, 16'h7FFF, 16'h7FFF);
        step();
        check("corner3 product", bus.out_product, 32'h3FFF0001);
        clr_req(1);
        step();

        // fairness: all valid, rotation 0,1,2,3,0,1,2,3
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 16'(i + 3), 16'(-(i + 1)));
        for (int n = 0; n < 8; n++) begin
            #1 check("rr grant", 32'(bus.in_ready), 32'd1 << (n % NREQ));
            step();
            check("rr out_id", 32'(bus.out_id), 32'(n % NREQ));
        end

        // backpressure: requester 3's result (6 * -4) held for 3 cycles
        bus.out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #1 check("bp in_ready", 32'(bus.in_ready), 32'd0);
            step();
            check("bp out_valid", 32'(bus.out_valid), 32'd1);
            check("bp out_id", 32'(bus.out_id), 32'd3);
            check("bp product", bus.out_product, 32'hFFFFFFE8);
        end
        bus.out_ready = 1'b1;
        #1 check("bp release grant", 32'(bus.in_ready), 32'b0001);
        step();
        check("bp next id", 32'(bus.out_id), 32'd0);
        check("bp next product", bus.out_product, 32'hFFFFFFFD);
        bus.in_valid = '0;
        step();

        // starvation: last=0, req0 and req2 valid -> 2 then 0
        set_req(0, 16'h0002, 16'h0003);
        set_req(2, 16'hFFFE, 16'h0005);
        #1 check("starve first", 32'(bus.in_ready), 32'b0100);
        step();
        clr_req(2);
        check("starve id2", 32'(bus.out_id), 32'd2);
        check("starve prod2", bus.out_product, 32'hFFFFFFF6);
        #1 check("starve second", 32'(bus.in_ready), 32'b0001);
        step();
        clr_req(0);
        check("starve id0", 32'(bus.out_id), 32'd0);
        check("starve prod0", bus.out_product, 32'h00000006);
        step();

        // reset mid-stream clears the pending result at once
        set_req(1, 16'h0005, 16'h0007);
        step();
        clr_req(1);
        check("mid pending", 32'(bus.out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1 check("mid async clear", 32'(bus.out_valid), 32'd0);
        check("mid async product", bus.out_product, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        set_req(3, 16'h0004, 16'h0004);
        set_req(0, 16'h0009, 16'hFFFF);
        #1 check("post rst grant", 32'(bus.in_ready), 32'b0001);
        step();
        clr_req(0);
        check("post rst id", 32'(bus.out_id), 32'd0);
        #1 check("post rst grant3", 32'(bus.in_ready), 32'b1000);
        step();
        clr_req(3);
        check("post rst id3", 32'(bus.out_id), 32'd3);
        step();

        // mixed traffic with random backpressure, checked by the model
        for (int n = 0; n < 80; n++) begin
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            #1 g = bus.in_ready;
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.in_valid[i] || g[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
                    else
                        clr_req(i);
                end
            end
        end
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("final drained", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
